// File: rtl/protobuf_field_encoder_if.sv
// Word-in / byte-out stream bundle for the protobuf field encoder.
// The slave side is the encoder; the master side drives words and sinks bytes.
interface protobuf_field_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_kind;
    logic [3:0]  in_strb;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    modport slave (
        input  in_valid, in_data, in_kind, in_strb, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_kind, in_strb, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/protobuf_field_encoder.sv
// Encodes one 32-bit field word at a time into protobuf wire bytes (varint,
// zigzag varint or raw payload); the next word loads on the final-byte handshake.
module protobuf_field_encoder #(
    parameter int CNT_W = 16
) (
    input  logic                 clock_clk,
    input  logic                 reset_reset,
    protobuf_field_encoder_if.slave bus,
    output logic [CNT_W-1:0]     byte_count,
    output logic                 err
);
    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       sr_reg, sr_next;
    logic [2:0]        rem_reg, rem_next;
    logic              raw_reg, raw_next;
    logic              last_reg, last_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              err_reg, err_next;

    logic              final_byte;
    logic              out_fire;
    logic              take;
    logic              strb_ok;
    logic              word_ok;
    logic [2:0]        strb_cnt;
    logic [31:0]       load_value;

    // Only contiguous lanes from byte 0 are legal, so popcount is a lookup.
    always_comb begin
        strb_ok  = 1'b1;
        strb_cnt = 3'd0;
        case (bus.in_strb)
            4'b0001: strb_cnt = 3'd1;
            4'b0011: strb_cnt = 3'd2;
            4'b0111: strb_cnt = 3'd3;
            4'b1111: strb_cnt = 3'd4;
            default: strb_ok  = 1'b0;
        endcase
    end

    assign word_ok = (bus.in_kind == 2'b00) || (bus.in_kind == 2'b01) ||
                     ((bus.in_kind == 2'b10) && strb_ok);

    assign load_value = (bus.in_kind == 2'b01)
                      ? ({bus.in_data[30:0], 1'b0} ^ {32{bus.in_data[31]}})
                      : bus.in_data;

    assign final_byte = raw_reg ? (rem_reg == 3'd1) : (sr_reg[31:7] == 25'd0);

    assign bus.out_valid = (state_reg == EMIT);
    assign bus.out_data  = raw_reg ? sr_reg[7:0] : {(sr_reg[31:7] != 25'd0), sr_reg[6:0]};
    assign bus.out_last  = (state_reg == EMIT) && final_byte && (!raw_reg || last_reg);
    // Held low during reset so every output reads 0 while reset is asserted.
    assign bus.in_ready  = !reset_reset &&
                           ((state_reg == IDLE) || (bus.out_ready && final_byte));

    assign out_fire = bus.out_valid && bus.out_ready;
    assign take     = bus.in_valid && bus.in_ready;

    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        rem_next   = rem_reg;
        raw_next   = raw_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;

        if (out_fire) begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (raw_reg) begin
                sr_next  = sr_reg >> 8;
                rem_next = rem_reg - 3'd1;
            end else begin
                sr_next  = sr_reg >> 7;
            end
            if (final_byte) begin
                state_next = IDLE;
            end
        end

        // A take in EMIT implies the final-byte handshake above, so the load
        // never collides with a byte still in flight.
        if (take) begin
            if (word_ok) begin
                state_next = EMIT;
                sr_next    = load_value;
                rem_next   = strb_cnt;
                raw_next   = (bus.in_kind == 2'b10);
                last_next  = (bus.in_kind == 2'b10) && bus.in_last;
            end else begin
                state_next = IDLE;
                err_next   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg <= IDLE;
            sr_reg    <= 32'd0;
            rem_reg   <= 3'd0;
            raw_reg   <= 1'b0;
            last_reg  <= 1'b0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            rem_reg   <= rem_next;
            raw_reg   <= raw_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    assign byte_count = cnt_reg;
    assign err        = err_reg;
endmodule

// File: tb/tb_protobuf_field_encoder.sv
// Self-checking bench: directed and random words against an arithmetic
// protobuf reference model; a monitor captures bytes and checks stall stability.
module tb_protobuf_field_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] byte_count;
    logic        err;

    protobuf_field_encoder_if bus ();

    protobuf_field_encoder #(.CNT_W(16)) dut (
        .clock_clk  (clk),
        .reset_reset(rst),
        .bus        (bus),
        .byte_count (byte_count),
        .err        (err)
    );

    int          cmp_cnt = 0;
    int          mis_cnt = 0;
    int          cycle   = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  got_q[$];
    int          got_cyc[$];
    int          exp_err   = 0;
    int          got_err   = 0;
    int          exp_count = 0;
    int          ready_mode = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  held_data  = 8'd0;
    logic        held_last  = 1'b0;
    int          base_count;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            mis_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // out_ready: 0 always 1, 1 random, 2 toggling, 3 held low.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            2:       bus.out_ready = ~bus.out_ready;
            default: bus.out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (err) got_err++;
            if (stall_prev) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data",  32'(bus.out_data),  32'(held_data));
                check("stall_last",  32'(bus.out_last),  32'(held_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back({bus.out_last, bus.out_data});
                got_cyc.push_back(cycle);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held_data  = bus.out_data;
            held_last  = bus.out_last;
        end
    end

    // Reference: protobuf encoding from its arithmetic definition.
    function automatic void model_push(input logic [1:0] kind, input logic [31:0] data,
                                       input logic [3:0] strb, input logic last);
        longint unsigned v;
        longint          s;
        int              n;
        logic [7:0]      b;
        if (kind == 2'b11) begin
            exp_err++;
            return;
        end
        if (kind == 2'b10) begin
            n = 0;
            for (int k = 1; k <= 4; k++)
                if (int'(strb) == (1 << k) - 1) n = k;
            if (n == 0) begin
                exp_err++;
                return;
            end
            for (int i = 0; i < n; i++) begin
                b = data[8*i +: 8];
                exp_q.push_back({(i == n - 1) && last, b});
            end
            exp_count += n;
            return;
        end
        if (kind == 2'b01) begin
            s = longint'($signed(data));
            v = (s >= 0) ? longint'(2 * s) : longint'(-2 * s - 1);
        end else begin
            v = longint'(data);
        end
        do begin
            b = 8'(v % 128);
            v = v / 128;
            if (v != 0) b = b + 8'd128;
            exp_q.push_back({(v == 0), b});
            exp_count++;
        end while (v != 0);
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [1:0] kind, input logic [31:0] data,
                        input logic [3:0] strb = 4'hf, input logic last = 1'b1);
        bit ok = 0;
        model_push(kind, data, strb, last);
        bus.in_valid = 1'b1;
        bus.in_kind  = kind;
        bus.in_data  = data;
        bus.in_strb  = strb;
        bus.in_last  = last;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i >= 1 && got_q.size() >= exp_q.size() && !bus.out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check({tag, "_drain_timeout"}, 32'd0, 32'd1);
        check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_byte_count"}, 32'(byte_count), 32'(exp_count % 65536));
        check({tag, "_err_pulses"}, 32'(got_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    logic [7:0] raw_exp [11];
    logic [1:0] rk;
    logic [3:0] rs;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.in_kind   = 2'b00;
        bus.in_strb   = 4'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        raw_exp = '{8'h6d, 8'h61, 8'h72, 8'h69, 8'h6f, 8'h20, 8'h61, 8'h64, 8'h6d, 8'h6f, 8'h6e};

        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_byte_count", 32'(byte_count),   32'd0);
        check("rst_err",       32'(err),           32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1 check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // Back-to-back single-byte varints with no bubble.
        send(2'b00, 32'd10);
        send(2'b00, 32'd51);
        drain("b2b");
        check("b2b_first",  32'(got_q[0]), 32'h10a);
        check("b2b_second", 32'(got_q[1]), 32'h133);
        check("b2b_no_gap", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
        check("b2b_count",  32'(byte_count), 32'd2);
        clear_q();

        send(2'b00, 32'd300);
        send(2'b00, 32'hFFFF_FFFF);
        send(2'b00, 32'd0);
        send(2'b01, 32'hFFFF_FFFF);
        send(2'b01, 32'd1);
        send(2'b01, 32'h8000_0000);
        drain("varint");
        check("v300_lo", 32'(got_q[0]), 32'h0ac);
        check("v300_hi", 32'(got_q[1]), 32'h102);
        check("zz_m1",   32'(got_q[8]), 32'h101);
        check("zz_p1",   32'(got_q[9]), 32'h102);
        clear_q();

        base_count = exp_count;
        send(2'b10, 32'h6972616d, 4'b1111, 1'b0);
        send(2'b10, 32'h6461206f, 4'b1111, 1'b0);
        send(2'b10, 32'h006e6f6d, 4'b0111, 1'b1);
        drain("raw");
        for (int i = 0; i < 11 && i < got_q.size(); i++)
            check($sformatf("raw_lit%0d", i), 32'(got_q[i]), 32'({i == 10, raw_exp[i]}));
        check("raw_count_delta", 32'(exp_count - base_count), 32'd11);
        clear_q();

        ready_mode = 2;
        send(2'b00, 32'hFFFF_FFFF);
        drain("toggle");
        check("toggle_last", 32'(got_q[4]), 32'h10f);
        clear_q();

        // Reset while a word is stalled mid-emit.
        ready_mode = 3;
        send(2'b00, 32'hFFFF_FFFF);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        check("midrst_count", 32'(byte_count), 32'd0);
        clear_q();
        exp_count = 0;
        got_err   = 0;
        exp_err   = 0;
        rst = 1'b0;
        ready_mode = 0;
        @(posedge clk); #1;
        send(2'b00, 32'd300);
        drain("post_rst");
        clear_q();

        send(2'b10, 32'h11223344, 4'b0101, 1'b1);
        drain("bad_strb");
        send(2'b00, 32'd10);
        drain("after_bad_strb");
        check("after_bad_strb_byte", 32'(got_q[0]), 32'h10a);
        clear_q();
        send(2'b11, 32'd5);
        drain("bad_kind");
        send(2'b00, 32'd10);
        drain("after_bad_kind");
        check("after_bad_kind_byte", 32'(got_q[0]), 32'h10a);
        clear_q();

        ready_mode = 1;
        for (int n = 0; n < 150; n++) begin
            rk = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: rs = 4'b0001;
                1: rs = 4'b0011;
                2: rs = 4'b0111;
                3: rs = 4'($urandom);
                default: rs = 4'b1111;
            endcase
            if ($urandom_range(0, 3) == 0)
                send(rk, $urandom >> $urandom_range(0, 31), rs, 1'($urandom));
            else
                send(rk, $urandom, rs, 1'($urandom));
        end
        drain("random");
        clear_q();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end
endmodule
